countdown_ctrl: RTL and testbench

- Sequencing controller for the two-digit BCD countdown datapath.
- Accepts debounced user buttons and the 1 Hz enable from the frequency divider.
- Owns the run/pause/load/alarm state machine and the BCD time register.
- Drives TimeH/TimeL to the seven-segment display path and beep to the buzzer.

---
 rtl/countdown_pkg.sv | 11 +
 rtl/countdown_ctrl_if.sv | 15 +
 rtl/bcd_dec2.sv | 15 +
 rtl/countdown_ctrl.sv | 102 ++++++++++
 tb/tb_countdown_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared states, BCD limits and default presets for the countdown blocks
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] DEF_PRESET_H = 4'd6;
  localparam logic [3:0] DEF_PRESET_L = 4'd0;
  localparam int unsigned DEF_ALARM_TICKS = 5;
  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: user buttons, tick and display/buzzer outputs of the countdown controller
interface countdown_ctrl_if;
  logic tick;
  logic start_btn;
  logic clear_btn;
  logic load_btn;
  logic [3:0] set_h;
  logic [3:0] set_l;
  logic [3:0] TimeH;
  logic [3:0] TimeL;
  logic beep;
  logic running;
  modport master(output tick, start_btn, clear_btn, load_btn, set_h, set_l, input TimeH, TimeL, beep, running);
  modport slave(input tick, start_btn, clear_btn, load_btn, set_h, set_l, output TimeH, TimeL, beep, running);
endinterface

// File: rtl/bcd_dec2.sv
// bcd_dec2: two-digit BCD decrement (00 wraps to 99) with a flag for a 00 result
module bcd_dec2 import countdown_pkg::*; (
  input  logic [3:0] h,
  input  logic [3:0] l,
  output logic [3:0] nh,
  output logic [3:0] nl,
  output logic       zero
);
  // units borrow from tens when they wrap past zero
  always_comb begin
    nl = (l == 4'd0) ? BCD_MAX : l - 4'd1;
    nh = (l != 4'd0) ? h : (h == 4'd0) ? BCD_MAX : h - 4'd1;
    zero = (nh == 4'd0) && (nl == 4'd0);
  end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/load/alarm sequencer owning the two-digit BCD time register
module countdown_ctrl import countdown_pkg::*; #(
  parameter logic [3:0] PRESET_H = DEF_PRESET_H,
  parameter logic [3:0] PRESET_L = DEF_PRESET_L,
  parameter int unsigned ALARM_TICKS = DEF_ALARM_TICKS
) (
  input logic clock,
  input logic reset,
  countdown_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [3:0] th, tl, th_nx, tl_nx, acnt, acnt_nx, dh, dl;
  logic dz, start_q, clear_q, load_q, armed;
  logic start_e, clear_e, load_e;
  bcd_dec2 u_dec (.h(th), .l(tl), .nh(dh), .nl(dl), .zero(dz));
  assign start_e = bus.start_btn & ~start_q & armed;
  assign clear_e = bus.clear_btn & ~clear_q & armed;
  assign load_e = bus.load_btn & ~load_q & armed;
  // button history; armed stays low for the first cycle so a button held through reset is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      clear_q <= 1'b0;
      load_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      clear_q <= bus.clear_btn;
      load_q <= bus.load_btn;
      armed <= 1'b1;
    end
  end
  // state, time and alarm counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      th <= PRESET_H;
      tl <= PRESET_L;
      acnt <= '0;
    end else begin
      state <= state_nx;
      th <= th_nx;
      tl <= tl_nx;
      acnt <= acnt_nx;
    end
  end
  // next state and datapath update; clear beats every state-specific action
  always_comb begin
    state_nx = state;
    th_nx = th;
    tl_nx = tl;
    acnt_nx = acnt;
    if (clear_e) begin
      state_nx = IDLE;
      th_nx = PRESET_H;
      tl_nx = PRESET_L;
      acnt_nx = '0;
    end else begin
      case (state)
        IDLE:
          if (start_e) state_nx = (th == 4'd0 && tl == 4'd0) ? IDLE : RUN;
          else if (load_e && is_bcd(bus.set_h) && is_bcd(bus.set_l)) begin
            th_nx = bus.set_h;
            tl_nx = bus.set_l;
          end
        RUN: begin
          if (bus.tick) begin
            th_nx = dh;
            tl_nx = dl;
          end
          acnt_nx = '0;
          state_nx = (bus.tick && dz) ? ALARM : start_e ? PAUSE : RUN;
        end
        PAUSE:
          if (start_e) state_nx = RUN;
        ALARM:
          if (bus.tick) begin
            acnt_nx = acnt + 4'd1;
            if (acnt_nx == 4'(ALARM_TICKS)) begin
              state_nx = IDLE;
              th_nx = PRESET_H;
              tl_nx = PRESET_L;
              acnt_nx = '0;
            end
          end
        default: begin
          state_nx = IDLE;
          th_nx = PRESET_H;
          tl_nx = PRESET_L;
          acnt_nx = '0;
        end
      endcase
    end
  end
  // outputs decode registered state only
  always_comb begin
    bus.TimeH = th;
    bus.TimeL = tl;
    bus.running = (state == RUN);
    bus.beep = (state == ALARM);
  end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: vector table, directed corner sequences and random run against a seconds-based model
module tb_countdown_ctrl;
  logic clock, reset;
  countdown_ctrl_if bus();
  countdown_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int n_cmp = 0, n_bad = 0;
  int m_mode, m_secs, m_ac;
  bit p_s, p_c, p_l;
  typedef struct {
    bit r, tk, s, c, l;
    logic [3:0] h, lo;
    int eh, el;
    bit eb, er;
  } vec_t;
  vec_t tv[18];
  task automatic chk(input string nm, input int eh, input int el, input bit eb, input bit er);
    n_cmp++;
    if (bus.TimeH !== 4'(eh) || bus.TimeL !== 4'(el) || bus.beep !== eb || bus.running !== er) begin
      n_bad++;
      $display("FAIL %s @%0t: got time=%0d%0d beep=%b run=%b, want time=%0d%0d beep=%b run=%b",
               nm, $time, bus.TimeH, bus.TimeL, bus.beep, bus.running, eh, el, eb, er);
    end
  endtask
  // mode: 0 idle, 1 run, 2 pause, 3 alarm; time kept as whole seconds
  task automatic model_step(input bit rs, input bit tk, input bit s, input bit c, input bit l, input int h, input int lo);
    bit se, ce, le;
    if (rs) begin
      m_mode = 0; m_secs = 60; m_ac = 0;
      p_s = 1; p_c = 1; p_l = 1;
      return;
    end
    se = s && !p_s; ce = c && !p_c; le = l && !p_l;
    p_s = s; p_c = c; p_l = l;
    if (ce) begin
      m_mode = 0; m_secs = 60; m_ac = 0;
    end else if (m_mode == 0) begin
      if (se) begin
        if (m_secs != 0) m_mode = 1;
      end else if (le && h <= 9 && lo <= 9) m_secs = h * 10 + lo;
    end else if (m_mode == 1) begin
      if (tk) m_secs = m_secs - 1;
      if (tk && m_secs == 0) begin
        m_mode = 3; m_ac = 0;
      end else if (se) m_mode = 2;
    end else if (m_mode == 2) begin
      if (se) m_mode = 1;
    end else if (tk) begin
      m_ac++;
      if (m_ac == 5) begin
        m_mode = 0; m_secs = 60;
      end
    end
  endtask
  task automatic cyc(input bit rs, input bit tk, input bit s, input bit c, input bit l, input logic [3:0] h, input logic [3:0] lo);
    reset = rs; bus.tick = tk; bus.start_btn = s; bus.clear_btn = c; bus.load_btn = l;
    bus.set_h = h; bus.set_l = lo;
    @(posedge clock);
    model_step(rs, tk, s, c, l, int'(h), int'(lo));
    #1;
    chk("model", m_secs / 10, m_secs % 10, m_mode == 3, m_mode == 1);
  endtask
  initial begin
    bit s, c, l, rs, tk;
    logic [3:0] h, lo;
    tv[0]  = '{1,0,0,0,0,0,0,  6,0,0,0};
    tv[1]  = '{0,0,0,0,0,0,0,  6,0,0,0};
    tv[2]  = '{0,0,1,0,0,0,0,  6,0,0,1};
    tv[3]  = '{0,1,1,0,0,0,0,  5,9,0,1};
    tv[4]  = '{0,1,0,0,0,0,0,  5,8,0,1};
    tv[5]  = '{0,1,0,0,0,0,0,  5,7,0,1};
    tv[6]  = '{0,0,1,0,0,0,0,  5,7,0,0};
    tv[7]  = '{0,0,0,1,0,0,0,  6,0,0,0};
    tv[8]  = '{0,0,0,0,1,1,0,  1,0,0,0};
    tv[9]  = '{0,0,0,0,0,0,0,  1,0,0,0};
    tv[10] = '{0,0,0,0,1,3,10, 1,0,0,0};
    tv[11] = '{0,0,1,0,0,0,0,  1,0,0,1};
    tv[12] = '{0,0,0,0,1,5,5,  1,0,0,1};
    tv[13] = '{0,1,0,0,0,0,0,  0,9,0,1};
    tv[14] = '{0,0,0,1,0,0,0,  6,0,0,0};
    tv[15] = '{0,0,0,0,1,0,0,  0,0,0,0};
    tv[16] = '{0,0,1,0,0,0,0,  0,0,0,0};
    tv[17] = '{0,0,0,0,0,0,0,  0,0,0,0};
    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].r, tv[i].tk, tv[i].s, tv[i].c, tv[i].l, tv[i].h, tv[i].lo);
      chk($sformatf("vec%0d", i), tv[i].eh, tv[i].el, tv[i].eb, tv[i].er);
    end
    cyc(0,0,0,0,1,1,0); chk("t2_load", 1,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t2_start", 1,0,0,1);
    for (int i = 1; i <= 10; i++) begin
      cyc(0,1,0,0,0,0,0);
      chk($sformatf("t2_tick%0d", i), 0, 10 - i, i == 10, i != 10);
      cyc(0,0,0,0,0,0,0);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(0,1,0,0,0,0,0);
      if (i < 5) chk($sformatf("t2_alarm%0d", i), 0,0,1,0);
      else chk("t2_alarm_done", 6,0,0,0);
    end
    cyc(0,0,0,0,1,4,5); chk("t3_load45", 4,5,0,0);
    cyc(0,0,1,0,0,0,0); chk("t3_run", 4,5,0,1);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t3_pause", 4,5,0,0);
    cyc(0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      cyc(0,1,0,0,0,0,0); chk("t3_pause_tick", 4,5,0,0);
    end
    cyc(0,0,1,0,0,0,0); chk("t3_resume", 4,5,0,1);
    cyc(0,0,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0); chk("t3_tick44", 4,4,0,1);
    cyc(0,1,1,0,0,0,0); chk("t3_start_tick", 4,3,0,0);
    cyc(0,0,0,1,0,0,0); chk("t3_clear", 6,0,0,0);
    cyc(0,0,0,0,1,0,1); chk("t3_load01", 0,1,0,0);
    cyc(0,0,1,0,0,0,0); chk("t3_run01", 0,1,0,1);
    cyc(0,0,0,0,0,0,0);
    cyc(0,1,1,0,0,0,0); chk("t3_alarm_wins", 0,0,1,0);
    cyc(0,1,0,0,0,0,0); chk("t5_mid_beep", 0,0,1,0);
    cyc(0,0,0,1,0,0,0); chk("t5_clear_alarm", 6,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t5_run", 6,0,0,1);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t5_pause", 6,0,0,0);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,1,1,0,0,0); chk("t5_clear_start", 6,0,0,0);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,2,3); chk("t6_load23", 2,3,0,0);
    cyc(0,0,1,0,0,0,0); chk("t6_run", 2,3,0,1);
    cyc(0,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0); chk("t6_reset_tick", 6,0,0,0);
    cyc(1,0,1,0,0,0,0); chk("t6_reset_held", 6,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t6_release", 6,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t6_still_held", 6,0,0,0);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0); chk("t6_new_edge", 6,0,0,1);
    s = 0; c = 0; l = 0;
    for (int i = 0; i < 4000; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      tk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) s = ~s;
      if ($urandom_range(0, 29) == 0) c = ~c;
      if ($urandom_range(0, 5) == 0) l = ~l;
      h = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
      lo = 4'($urandom_range(0, 11));
      cyc(rs, tk, s, c, l, h, lo);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
